// File: rtl/mimo_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the MIMO
// transmit-side stimulus source.
package mimo_pkg;

    localparam int INT_W   = 6;
    localparam int FRAC_W  = 10;
    localparam int I_WIDTH = INT_W + FRAC_W;
    localparam int ACC_W   = 21;
    localparam int N_ANT   = 4;
    localparam int ENTRY_W = 2 * I_WIDTH;
    localparam int ROW_W   = I_WIDTH * 8;
    localparam int SYM_W   = 3 * N_ANT;

    // Entry j of a packed row is {im, re}, re in the low half.
    localparam int RE_OFS  = 0;
    localparam int IM_OFS  = I_WIDTH;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 21'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -21'sd32768;

    typedef enum logic [2:0] {
        S_H_LOAD = 3'd0,
        S_H_SEND = 3'd1,
        S_WAIT   = 3'd2,
        S_CALC   = 3'd3,
        S_D_SEND = 3'd4
    } state_e;

    typedef struct packed {
        logic signed [2:0] re;
        logic signed [2:0] im;
    } qam8_t;

    function automatic qam8_t qam8_decode(input logic [2:0] idx);
        qam8_t p;
        case (idx[1:0])
            2'b00:   p.re = -3'sd3;
            2'b01:   p.re = -3'sd1;
            2'b10:   p.re = 3'sd1;
            default: p.re = 3'sd3;
        endcase
        p.im = idx[2] ? 3'sd1 : -3'sd1;
        return p;
    endfunction

    // Multiply by a constellation coordinate using only shifts and adds.
    function automatic logic signed [ACC_W-1:0] scale(input logic signed [I_WIDTH-1:0] h,
                                                      input logic signed [2:0] k);
        logic signed [ACC_W-1:0] ext;
        logic signed [ACC_W-1:0] res;
        ext = {{(ACC_W-I_WIDTH){h[I_WIDTH-1]}}, h};
        case (k)
            3'b011:  res = (ext <<< 1) + ext;
            3'b001:  res = ext;
            3'b111:  res = -ext;
            3'b101:  res = -((ext <<< 1) + ext);
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [I_WIDTH-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic [I_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = 16'h7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'h8000;
        end else begin
            r = v[I_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mimo_row_mac.sv
// Combinational complex dot product of one H row with four 8-QAM symbols,
// saturated to the 16-bit output format.
module mimo_row_mac
    import mimo_pkg::*;
(
    input  logic [ROW_W-1:0]     h_row_i,
    input  logic [SYM_W-1:0]     sym_i,
    output logic [ENTRY_W-1:0]   y_o
);

    logic signed [ACC_W-1:0]   acc_re;
    logic signed [ACC_W-1:0]   acc_im;
    logic signed [I_WIDTH-1:0] hr;
    logic signed [I_WIDTH-1:0] hi;
    qam8_t                     x;

    always_comb begin
        acc_re = '0;
        acc_im = '0;
        hr     = '0;
        hi     = '0;
        x      = '0;
        for (int j = 0; j < N_ANT; j++) begin
            hr     = h_row_i[ENTRY_W*j + RE_OFS +: I_WIDTH];
            hi     = h_row_i[ENTRY_W*j + IM_OFS +: I_WIDTH];
            x      = qam8_decode(sym_i[3*j +: 3]);
            acc_re = acc_re + scale(hr, x.re) - scale(hi, x.im);
            acc_im = acc_im + scale(hr, x.im) + scale(hi, x.re);
        end
    end

    assign y_o = {sat16(acc_im), sat16(acc_re)};

endmodule

// File: rtl/mimo_tx_source.sv
// Loads H, forwards it as four channel beats, then turns each symbol word
// into one y = H*x data beat for the detector, honouring its backpressure.
module mimo_tx_source
    import mimo_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             h_valid,
    output logic             h_ready,
    input  logic [ROW_W-1:0] h_row,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_sym,
    input  logic             i_in_ready,
    output logic             o_in_valid,
    output logic             o_flag,
    output logic [ROW_W-1:0] o_data,
    output logic             o_busy
);

    // state    | meaning
    // S_H_LOAD | accepting H rows, cnt_q = next row index
    // S_H_SEND | offering H row cnt_q as a channel beat
    // S_WAIT   | idle; new H takes priority over a symbol word
    // S_CALC   | computing y row cnt_q into y_q
    // S_D_SEND | offering {y3,y2,y1,y0} as a data beat

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [ROW_W-1:0]   h_q [N_ANT];
    logic [ROW_W-1:0]   h_d [N_ANT];
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [ENTRY_W-1:0] y_q [N_ANT];
    logic [ENTRY_W-1:0] y_d [N_ANT];
    logic [ENTRY_W-1:0] mac_y;

    mimo_row_mac u_row_mac (
        .h_row_i (h_q[cnt_q]),
        .sym_i   (sym_q),
        .y_o     (mac_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        sym_d   = sym_q;
        y_d     = y_q;
        case (state_q)
            S_H_LOAD: begin
                if (h_valid) begin
                    h_d[cnt_q] = h_row;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_H_SEND;
                    end
                end
            end
            S_H_SEND: begin
                if (i_in_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (h_valid) begin
                    h_d[0]  = h_row;
                    cnt_d   = 2'd1;
                    state_d = S_H_LOAD;
                end else if (s_valid) begin
                    sym_d   = s_sym;
                    cnt_d   = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                y_d[cnt_q] = mac_y;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_D_SEND;
                end
            end
            S_D_SEND: begin
                if (i_in_ready) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_H_LOAD;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_H_LOAD;
            cnt_q   <= '0;
            sym_q   <= '0;
            for (int i = 0; i < N_ANT; i++) begin
                h_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            h_q     <= h_d;
            y_q     <= y_d;
        end
    end

    assign h_ready    = (state_q == S_H_LOAD) || (state_q == S_WAIT);
    assign s_ready    = (state_q == S_WAIT) && !h_valid;
    assign o_in_valid = (state_q == S_H_SEND) || (state_q == S_D_SEND);
    assign o_flag     = (state_q == S_H_SEND);
    assign o_busy     = (state_q != S_WAIT);

    always_comb begin
        o_data = '0;
        if (state_q == S_H_SEND) begin
            o_data = h_q[cnt_q];
        end else if (state_q == S_D_SEND) begin
            o_data = {y_q[3], y_q[2], y_q[1], y_q[0]};
        end
    end

endmodule

// File: tb/tb_mimo_tx_source.sv
// Randomized self-checking bench for mimo_tx_source against an integer
// reference model of y = H*x with 8-QAM symbols and 16-bit saturation.
module tb_mimo_tx_source;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         h_valid = 1'b0;
    logic         h_ready;
    logic [127:0] h_row = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [11:0]  s_sym = '0;
    logic         i_in_ready = 1'b0;
    logic         o_in_valid;
    logic         o_flag;
    logic [127:0] o_data;
    logic         o_busy;

    int checks = 0;
    int failures = 0;
    logic [127:0] hm [4];

    mimo_tx_source dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_row      (h_row),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sym      (s_sym),
        .i_in_ready (i_in_ready),
        .o_in_valid (o_in_valid),
        .o_flag     (o_flag),
        .o_data     (o_data),
        .o_busy     (o_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat(input int v);
        logic [31:0] w;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        w = v;
        return w[15:0];
    endfunction

    // y_i = sum_j H_ij * x_j with x_re = 2*idx[1:0]-3, x_im = idx[2] ? +1 : -1
    function automatic logic [31:0] ref_row(input logic [127:0] row, input logic [11:0] sym);
        int re, im, hr, hi, xr, xi;
        logic [2:0] idx;
        re = 0;
        im = 0;
        for (int j = 0; j < 4; j++) begin
            hr  = int'($signed(row[32*j +: 16]));
            hi  = int'($signed(row[32*j+16 +: 16]));
            idx = sym[3*j +: 3];
            xr  = 2 * int'(idx[1:0]) - 3;
            xi  = idx[2] ? 1 : -1;
            re  = re + hr * xr - hi * xi;
            im  = im + hr * xi + hi * xr;
        end
        return {sat(im), sat(re)};
    endfunction

    function automatic logic [127:0] ref_data(input logic [11:0] sym);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = ref_row(hm[i], sym);
        return d;
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        logic [15:0]  v;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) == 0) v = 16'($urandom);
            else v = 16'($urandom_range(0, 4095)) - 16'd2048;
            r[16*k +: 16] = v;
        end
        return r;
    endfunction

    // All tasks start and end at posedge+1.
    task automatic push_h(input logic [127:0] row);
        int n = 0;
        h_valid = 1'b1;
        h_row   = row;
        #1;
        while (!h_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("h_accept_timeout", 128'(n < 50), 128'(1));
        @(posedge Clk); #1;
        h_valid = 1'b0;
    endtask

    task automatic push_s(input logic [11:0] sym);
        int n = 0;
        s_valid = 1'b1;
        s_sym   = sym;
        #1;
        while (!s_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("s_accept_timeout", 128'(n < 50), 128'(1));
        @(posedge Clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic exp_flag,
                               input logic [127:0] exp_data, input bit bp);
        int n = 0;
        bit held = 0;
        bit done = 0;
        logic [127:0] prev;
        while (!done && n < 200) begin
            i_in_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (o_in_valid) begin
                if (held) check({tag, "_hold"}, o_data, prev);
                if (i_in_ready) begin
                    check({tag, "_flag"}, 128'(o_flag), 128'(exp_flag));
                    check(tag, o_data, exp_data);
                    done = 1;
                end else begin
                    held = 1;
                    prev = o_data;
                end
            end
            @(posedge Clk); #1;
            n++;
        end
        i_in_ready = 1'b0;
        check({tag, "_timeout"}, 128'(done), 128'(1));
    endtask

    task automatic load_and_send(input bit bp);
        for (int r = 0; r < 4; r++) push_h(hm[r]);
        for (int r = 0; r < 4; r++) expect_beat("chan", 1'b1, hm[r], bp);
    endtask

    task automatic send_sym(input logic [11:0] sym, input bit bp);
        push_s(sym);
        expect_beat("data", 1'b0, ref_data(sym), bp);
    endtask

    initial begin
        logic [11:0] sym;

        repeat (3) @(posedge Clk);
        #1;
        Reset   = 1'b0;
        s_valid = 1'b1;
        #1;
        check("rst_h_ready", 128'(h_ready), 128'(1));
        check("rst_s_ready", 128'(s_ready), 128'(0));
        check("rst_valid", 128'(o_in_valid), 128'(0));
        check("rst_flag", 128'(o_flag), 128'(0));
        check("rst_data", o_data, 128'(0));
        check("rst_busy", 128'(o_busy), 128'(1));
        s_valid = 1'b0;
        @(posedge Clk); #1;

        // Identity H, then latency and value of the first data beat
        for (int i = 0; i < 4; i++) begin
            hm[i] = '0;
            hm[i][32*i +: 16] = 16'h0400;
        end
        load_and_send(0);
        push_s(12'hFFF);
        i_in_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge Clk); #1;
            check($sformatf("latency_valid_%0d", k), 128'(o_in_valid), 128'(k == 4));
        end
        check("id_fff", o_data, ref_data(12'hFFF));
        check("id_fff_flag", 128'(o_flag), 128'(0));
        @(posedge Clk); #1;
        check("idle_busy", 128'(o_busy), 128'(0));
        check("idle_valid", 128'(o_in_valid), 128'(0));
        i_in_ready = 1'b0;
        send_sym(12'h000, 0);

        // Saturation corner
        for (int i = 0; i < 4; i++) hm[i] = {4{32'h0000_7FFF}};
        load_and_send(1);
        send_sym(12'h6DB, 1);

        // Backpressure held on channel row 1
        for (int i = 0; i < 4; i++) hm[i] = rand_row();
        for (int r = 0; r < 4; r++) push_h(hm[r]);
        i_in_ready = 1'b1;
        #1;
        check("bp_row0", o_data, hm[0]);
        @(posedge Clk); #1;
        i_in_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_row1_hold", o_data, hm[1]);
            check("bp_row1_flag", 128'(o_flag), 128'(1));
            @(posedge Clk); #1;
        end
        i_in_ready = 1'b1;
        #1;
        check("bp_row1", o_data, hm[1]);
        @(posedge Clk); #1;
        i_in_ready = 1'b0;
        expect_beat("bp_row2", 1'b1, hm[2], 0);
        expect_beat("bp_row3", 1'b1, hm[3], 0);
        send_sym(12'($urandom), 1);

        // H and symbol offered together in S_WAIT
        for (int i = 0; i < 4; i++) hm[i] = rand_row();
        h_valid = 1'b1;
        h_row   = hm[0];
        s_valid = 1'b1;
        s_sym   = 12'($urandom);
        #1;
        check("prio_s_ready", 128'(s_ready), 128'(0));
        check("prio_h_ready", 128'(h_ready), 128'(1));
        @(posedge Clk); #1;
        h_valid = 1'b0;
        #1;
        check("prio_busy", 128'(o_busy), 128'(1));
        check("prio_load_s_ready", 128'(s_ready), 128'(0));
        s_valid = 1'b0;
        for (int r = 1; r < 4; r++) push_h(hm[r]);
        for (int r = 0; r < 4; r++) expect_beat("prio_chan", 1'b1, hm[r], 1);
        send_sym(12'($urandom), 0);

        // Randomized frames with occasional H reloads
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < 4; i++) hm[i] = rand_row();
                load_and_send(1);
            end
            sym = 12'($urandom);
            send_sym(sym, 1);
        end

        // Reset during the third CALC cycle
        push_s(12'($urandom));
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        check("midrst_valid", 128'(o_in_valid), 128'(0));
        check("midrst_h_ready", 128'(h_ready), 128'(1));
        check("midrst_busy", 128'(o_busy), 128'(1));
        check("midrst_data", o_data, 128'(0));
        i_in_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            check("midrst_no_beat", 128'(o_in_valid), 128'(0));
        end
        i_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) hm[i] = rand_row();
        load_and_send(1);
        send_sym(12'($urandom), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
